// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for the unified memory's data port: IDLE->ACCESS->RESP per access, registered read data.
// Optional MEM_BOUNDS_CHECK_EN macro enables the out-of-range / misaligned address check.
module mem_port_arbiter #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 32,
   parameter int MEM_BYTES = 16384,
   parameter int PRIO_MODE = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_ack,
   output logic [DATA_W-1:0] m0_rdata,
   output logic              m0_err,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_ack,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              m1_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_wr_en,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

`ifdef MEM_BOUNDS_CHECK_EN
   localparam bit BOUNDS_EN = 1'b1;
`else
   localparam bit BOUNDS_EN = 1'b0;
`endif
   localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(MEM_BYTES);

   state_t            state, state_next;
   logic              sel, we_q, err_q, last_grant;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q, rdata_q;

   logic              grant_valid, grant_sel, grant_we, grant_err;
   logic [ADDR_W-1:0] grant_addr;
   logic [DATA_W-1:0] grant_wdata;

   // Round-robin favours the master that did not win last; fixed priority always favours m0.
   always_comb begin
      grant_valid = m0_req | m1_req;
      grant_sel   = 1'b0;
      if (m1_req && !m0_req) begin
         grant_sel = 1'b1;
      end else if (m0_req && m1_req && PRIO_MODE == 0) begin
         grant_sel = ~last_grant;
      end
      grant_we    = grant_sel ? m1_we    : m0_we;
      grant_addr  = grant_sel ? m1_addr  : m0_addr;
      grant_wdata = grant_sel ? m1_wdata : m0_wdata;
      grant_err   = BOUNDS_EN &&
                    ((grant_addr >= MEM_LIMIT) || (grant_addr[1:0] != 2'b00));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (grant_valid) state_next = ACCESS;
         ACCESS:  state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Request fields are captured once at grant so requesters may change them right after ack.
   always_ff @(posedge clk) begin
      if (reset) begin
         sel        <= 1'b0;
         we_q       <= 1'b0;
         err_q      <= 1'b0;
         last_grant <= 1'b1;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
      end else begin
         if (state == IDLE && grant_valid) begin
            sel        <= grant_sel;
            we_q       <= grant_we;
            err_q      <= grant_err;
            addr_q     <= grant_addr;
            wdata_q    <= grant_wdata;
            last_grant <= grant_sel;
         end
         if (state == ACCESS) begin
            rdata_q <= err_q ? '0 : mem_rdata;
         end
      end
   end

   // Reset gates the strobe directly so a reset landing in ACCESS never writes.
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_wr_en = (state == ACCESS) & we_q & ~err_q & ~reset;

   assign m0_ack   = (state == RESP) & ~sel;
   assign m1_ack   = (state == RESP) &  sel;
   assign m0_rdata = rdata_q;
   assign m1_rdata = rdata_q;
   assign m0_err   = m0_ack & err_q;
   assign m1_err   = m1_ack & err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a round-robin instance and a fixed-priority instance, each with a word memory model.
module tb_mem_port_arbiter;

`ifdef MEM_BOUNDS_CHECK_EN
   localparam bit BOUNDS = 1'b1;
`else
   localparam bit BOUNDS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   int          checks = 0;
   int          failures = 0;

   logic        m0_req, m0_we, m0_ack, m0_err, m1_req, m1_we, m1_ack, m1_err, mem_wr_en;
   logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [31:0] mem [0:4095];

   logic        p_m0_req, p_m0_we, p_m0_ack, p_m0_err, p_m1_req, p_m1_we, p_m1_ack, p_m1_err, p_mem_wr_en;
   logic [31:0] p_m0_addr, p_m0_wdata, p_m0_rdata, p_m1_addr, p_m1_wdata, p_m1_rdata;
   logic [31:0] p_mem_addr, p_mem_wdata, p_mem_rdata;
   logic [31:0] p_mem [0:4095];

   always #5 clk = ~clk;

   mem_port_arbiter #(.PRIO_MODE(0)) dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr_en(mem_wr_en), .mem_rdata(mem_rdata)
   );

   mem_port_arbiter #(.PRIO_MODE(1)) dut_prio (
      .clk(clk), .reset(reset),
      .m0_req(p_m0_req), .m0_we(p_m0_we), .m0_addr(p_m0_addr), .m0_wdata(p_m0_wdata),
      .m0_ack(p_m0_ack), .m0_rdata(p_m0_rdata), .m0_err(p_m0_err),
      .m1_req(p_m1_req), .m1_we(p_m1_we), .m1_addr(p_m1_addr), .m1_wdata(p_m1_wdata),
      .m1_ack(p_m1_ack), .m1_rdata(p_m1_rdata), .m1_err(p_m1_err),
      .mem_addr(p_mem_addr), .mem_wdata(p_mem_wdata), .mem_wr_en(p_mem_wr_en), .mem_rdata(p_mem_rdata)
   );

   // Memory models: combinational read, write at the clock edge.
   assign mem_rdata   = mem[mem_addr[13:2]];
   assign p_mem_rdata = p_mem[p_mem_addr[13:2]];

   always @(posedge clk) begin
      if (mem_wr_en) mem[mem_addr[13:2]] <= mem_wdata;
      if (p_mem_wr_en) p_mem[p_mem_addr[13:2]] <= p_mem_wdata;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic apply_stimulus(input int port, input logic req, input logic we,
                                 input logic [31:0] addr, input logic [31:0] wdata);
      if (port == 0) begin
         m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
      end else begin
         m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
      end
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) begin
         mem[i] = 32'h0;
         p_mem[i] = 32'h0;
      end
      mem[0]      = 32'h1111_0000;
      mem[32]     = 32'hCAFE_0080;
      mem[64]     = 32'h0BAD_0100;
      mem[128]    = 32'h0000_0200;
      mem[129]    = 32'h0000_0204;
      p_mem[4]    = 32'hAAAA_0010;
      p_mem[8]    = 32'hBBBB_0020;

      reset = 1'b1;
      apply_stimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
      apply_stimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
      p_m0_req = 1'b0; p_m0_we = 1'b0; p_m0_addr = 32'h0; p_m0_wdata = 32'h0;
      p_m1_req = 1'b0; p_m1_we = 1'b0; p_m1_addr = 32'h0; p_m1_wdata = 32'h0;
      $display("[TB] reset");
      tick();
      tick();
      check_output("rst_acks", {30'd0, m0_ack, m1_ack}, 32'd0);
      check_output("rst_errs", {30'd0, m0_err, m1_err}, 32'd0);
      check_output("rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
      check_output("rst_addr", mem_addr, 32'h0);
      check_output("rst_wdata", mem_wdata, 32'h0);
      check_output("rst_rdata", m0_rdata, 32'h0);
      reset = 1'b0;

      // Test 1: m0 write then read-back
      $display("[TB] m0 write 0x40 and read-back");
      apply_stimulus(0, 1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF);
      check_output("t1_idle_wr_en", {31'd0, mem_wr_en}, 32'd0);
      tick();
      check_output("t1_access_wr_en", {31'd0, mem_wr_en}, 32'd1);
      check_output("t1_access_addr", mem_addr, 32'h40);
      check_output("t1_access_ack", {31'd0, m0_ack}, 32'd0);
      tick();
      check_output("t1_resp_ack", {30'd0, m0_ack, m1_ack}, 32'd2);
      check_output("t1_resp_wr_en", {31'd0, mem_wr_en}, 32'd0);
      check_output("t1_mem_word", mem[16], 32'hDEAD_BEEF);
      apply_stimulus(0, 1'b0, 1'b0, 32'h40, 32'h0);
      tick();
      check_output("t1_idle_ack", {31'd0, m0_ack}, 32'd0);
      apply_stimulus(0, 1'b1, 1'b0, 32'h40, 32'h0);
      tick();
      tick();
      check_output("t1_rd_ack", {31'd0, m0_ack}, 32'd1);
      check_output("t1_rd_data", m0_rdata, 32'hDEAD_BEEF);
      apply_stimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();

      // Test 2: round-robin alternation from a fresh reset
      $display("[TB] round-robin, both held");
      reset = 1'b1;
      tick();
      reset = 1'b0;
      apply_stimulus(0, 1'b1, 1'b0, 32'h40, 32'h0);
      apply_stimulus(1, 1'b1, 1'b0, 32'h80, 32'h0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check_output("t2_access_acks", {30'd0, m0_ack, m1_ack}, 32'd0);
         tick();
         if (i % 2 == 0) begin
            check_output("t2_ack_m0", {30'd0, m0_ack, m1_ack}, 32'd2);
            check_output("t2_rdata_m0", m0_rdata, 32'hDEAD_BEEF);
         end else begin
            check_output("t2_ack_m1", {30'd0, m0_ack, m1_ack}, 32'd1);
            check_output("t2_rdata_m1", m1_rdata, 32'hCAFE_0080);
         end
         if (i == 3) begin
            apply_stimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
            apply_stimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
         end
         tick();
         check_output("t2_idle_acks", {30'd0, m0_ack, m1_ack}, 32'd0);
      end

      // Test 3: fixed priority, m1 waits until m0 drops
      $display("[TB] fixed priority, both held");
      p_m0_req = 1'b1; p_m0_addr = 32'h10;
      p_m1_req = 1'b1; p_m1_addr = 32'h20;
      for (int i = 0; i < 3; i++) begin
         tick();
         tick();
         check_output("t3_ack_m0", {30'd0, p_m0_ack, p_m1_ack}, 32'd2);
         check_output("t3_rdata_m0", p_m0_rdata, 32'hAAAA_0010);
         if (i == 2) p_m0_req = 1'b0;
         tick();
      end
      tick();
      tick();
      check_output("t3_ack_m1", {30'd0, p_m0_ack, p_m1_ack}, 32'd1);
      check_output("t3_rdata_m1", p_m1_rdata, 32'hBBBB_0020);
      p_m1_req = 1'b0;
      tick();

      // Test 4: reset during m1 write ACCESS
      $display("[TB] reset during access");
      apply_stimulus(1, 1'b1, 1'b1, 32'h100, 32'h1234_5678);
      tick();
      reset = 1'b1;
      apply_stimulus(1, 1'b0, 1'b0, 32'h100, 32'h0);
      #1;
      check_output("t4_wr_en_suppressed", {31'd0, mem_wr_en}, 32'd0);
      tick();
      reset = 1'b0;
      check_output("t4_no_ack", {30'd0, m0_ack, m1_ack}, 32'd0);
      check_output("t4_mem_word", mem[64], 32'h0BAD_0100);
      tick();
      check_output("t4_still_no_ack", {30'd0, m0_ack, m1_ack}, 32'd0);
      apply_stimulus(1, 1'b1, 1'b0, 32'h100, 32'h0);
      tick();
      tick();
      check_output("t4_rd_ack", {30'd0, m0_ack, m1_ack}, 32'd1);
      check_output("t4_rd_data", m1_rdata, 32'h0BAD_0100);
      apply_stimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();

      // Test 5: out-of-range and misaligned writes
      $display("[TB] bounds check, enabled=%0d", BOUNDS);
      apply_stimulus(0, 1'b1, 1'b1, 32'h4000, 32'h5555_AAAA);
      tick();
      check_output("t5a_wr_en", {31'd0, mem_wr_en}, {31'd0, ~BOUNDS});
      tick();
      check_output("t5a_ack", {30'd0, m0_ack, m0_err}, {30'd0, 1'b1, BOUNDS});
      check_output("t5a_rdata", m0_rdata, BOUNDS ? 32'h0 : 32'h1111_0000);
      check_output("t5a_mem", mem[0], BOUNDS ? 32'h1111_0000 : 32'h5555_AAAA);
      apply_stimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      apply_stimulus(0, 1'b1, 1'b1, 32'h42, 32'h7777_8888);
      tick();
      check_output("t5b_wr_en", {31'd0, mem_wr_en}, {31'd0, ~BOUNDS});
      tick();
      check_output("t5b_ack", {30'd0, m0_ack, m0_err}, {30'd0, 1'b1, BOUNDS});
      check_output("t5b_rdata", m0_rdata, BOUNDS ? 32'h0 : 32'hDEAD_BEEF);
      apply_stimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();

      // Test 6: m1 arrives in the cycle after m0_ack while m0 re-requests
      $display("[TB] back-to-back round-robin");
      apply_stimulus(0, 1'b1, 1'b0, 32'h200, 32'h0);
      tick();
      tick();
      check_output("t6_first_m0", {30'd0, m0_ack, m1_ack}, 32'd2);
      tick();
      apply_stimulus(1, 1'b1, 1'b0, 32'h204, 32'h0);
      tick();
      tick();
      check_output("t6_m1_first", {30'd0, m0_ack, m1_ack}, 32'd1);
      check_output("t6_m1_rdata", m1_rdata, 32'h0000_0204);
      apply_stimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      tick();
      tick();
      check_output("t6_m0_second", {30'd0, m0_ack, m1_ack}, 32'd2);
      check_output("t6_m0_rdata", m0_rdata, 32'h0000_0200);
      apply_stimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
